acc_processor_p: RTL
====================

Name: acc_processor_p

Overview:
- Parametrised multi-cycle accumulator processor; successor to the fixed 8-bit Processor core.
- Generic data width and program depth, a loadable program RAM, a selectable start address (mode), a pause control, a carry/borrow flag (CB) and a registered Output port with a valid strobe.
- Sits between the board-level control (pause/mode/start) and the display/output logic.

Parameters:
- DATA_W, 8, accumulator/Output/operand width (>=4)
- DEPTH, 16, program RAM words (power of two, >=2)
- ADDR_W, $clog2(DEPTH), PC/mode width; must be <= DATA_W

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- pause  in  1  1 = freeze all state (PC, ACC, CB, FSM); ignored in IDLE/HALT
- start  in  1  sampled in IDLE or HALT: begin execution at address mode
- mode  in  ADDR_W  start address latched into PC on accepted start
- prog_we  in  1  program RAM write strobe
- prog_addr  in  ADDR_W  program RAM write address
- prog_data  in  DATA_W+4  instruction: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] operand
- busy  out  1  1 in FETCH/EXEC
- halted  out  1  1 in HALT
- CB  out  1  carry/borrow flag
- Output  out  DATA_W  last value written by OUT
- out_valid  out  1  one-cycle pulse after each OUT

Behaviour:
- Reset (async, rstn=0): FSM=IDLE, PC=0, ACC=0, CB=0, Output=0, out_valid=0, busy=0, halted=0. Program RAM is not cleared.
- FSM states and transitions:
  - IDLE --start--> FETCH, with PC<=mode.
  - FETCH: IR<=RAM[PC]; then EXEC.
  - EXEC: execute IR; then FETCH, or HALT on opcode F.
  - HALT --start--> FETCH, with PC<=mode. ACC and CB are kept.
  - Each instruction takes exactly 2 cycles.
- pause=1 in FETCH/EXEC: no register changes; out_valid forced 0. Release resumes the same state with no lost or repeated instruction.
- Program writes:
  - prog_we is honoured only in IDLE/HALT; ignored while busy.
  - prog_we and start in the same cycle: the write lands. The first FETCH (next cycle) reads the new word if the addresses match.
- Opcodes (operand = op, width DATA_W). Unless noted, CB is unchanged and PC<=PC+1.
  - 0 NOP.
  - 1 LDI: ACC<=op; CB<=0.
  - 2 ADD: {CB,ACC}<=ACC+op (DATA_W+1-bit sum).
  - 3 SUB: ACC<=ACC-op mod 2^DATA_W; CB<=(op>ACC) (borrow).
  - 4 AND, 5 OR, 6 XOR: ACC<=ACC op op.
  - 7 SHL: CB<=ACC[MSB]; ACC<=ACC<<1.
  - 8 SHR: CB<=ACC[0]; ACC<=ACC>>1.
  - 9 OUT: Output<=ACC; out_valid=1 during the next cycle only.
  - A JMP: PC<=op[ADDR_W-1:0].
  - B JNC: jump if CB=0.
  - C JC: jump if CB=1.
  - D JZ: see Optional Feature.
  - E reserved: NOP.
  - F HALT: PC not advanced; FSM->HALT.
- PC increment wraps DEPTH-1 -> 0. Jump operand upper bits above ADDR_W are ignored.
- Reset asserted mid-instruction: immediate return to reset values; in-flight instruction is discarded.

Optional Feature:
- Macro: ACC_PROCESSOR_ZFLAG_EN.
- Defined:
  - Adds output port Z (1 bit), reset value 0.
  - Z is updated on every ACC-writing opcode (1,2,3,4,5,6,7,8): Z=(new ACC==0).
  - Opcode D JZ jumps to op when Z=1.
- Undefined:
  - No Z port.
  - Opcode D behaves as NOP.

Test Plan:
- Load [0]=LDI 0xF0, [1]=ADD 0x20, [2]=OUT, [3]=HALT; start with mode=0 -> out_valid pulse with Output=0x10, CB=1; halted=1 eight cycles after start accepted.
- Load [4]=LDI 0x05, [5]=SUB 0x07, [6]=OUT, [7]=HALT; start with mode=4 -> Output=0xFE, CB=1; then SUB 0x01 program from 0x05 -> Output=0x04, CB=0.
- Counting loop [0]=LDI 0, [1]=ADD 1, [2]=OUT, [3]=JNC 1; pause held 5 cycles mid-run -> Output sequence 0x01..0xFF then 0x00 with CB=1, falls through to [4]=HALT. No value skipped or repeated across the pause; out_valid stays 0 while paused.
- DEPTH=16, [15]=LDI 0x3C, [0]=OUT, [1]=HALT, start with mode=15 -> PC wraps 15->0; Output=0x3C.
- Reset during EXEC of ADD -> Output=0, CB=0, busy=0 immediately. prog_we while busy leaves RAM unchanged, verified by rerun.
- With ACC_PROCESSOR_ZFLAG_EN: [0]=LDI 3, [1]=SUB 1, [2]=JZ 4, [3]=JMP 1, [4]=OUT, [5]=HALT -> Output=0x00, Z=1. Without the macro, the same program loops forever and never halts.

Source files
------------

// File: rtl/acc_processor_p.sv
// acc_processor_p: parametrised accumulator processor, two cycles (FETCH, EXEC) per instruction.
// Optional zero flag output Z and JZ opcode are enabled by defining ACC_PROCESSOR_ZFLAG_EN.
module acc_processor_p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pause,
    input  logic              start,
    input  logic [ADDR_W-1:0] mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W+3:0] prog_data,
    output logic              busy,
    output logic              halted,
    output logic              CB,
    output logic [DATA_W-1:0] Output,
    output logic              out_valid
`ifdef ACC_PROCESSOR_ZFLAG_EN
    ,
    output logic              Z
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JNC  = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
`ifdef ACC_PROCESSOR_ZFLAG_EN
    localparam logic [3:0] OP_JZ   = 4'hD;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W+3:0]   ir;
    logic [DATA_W+3:0]   mem [DEPTH];

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   operand;
    logic [ADDR_W-1:0]   target;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   acc_next;
    logic                cb_next;
    logic                take_jump;
    logic                idle_like;
    logic                accept;

    assign opcode    = ir[DATA_W+3:DATA_W];
    assign operand   = ir[DATA_W-1:0];
    assign target    = operand[ADDR_W-1:0];
    assign sum       = {1'b0, acc} + {1'b0, operand};
    assign idle_like = (state == IDLE) || (state == HALT);
    assign accept    = idle_like && start;

`ifdef ACC_PROCESSOR_ZFLAG_EN
    logic acc_wr;
    assign acc_wr = (opcode >= OP_LDI) && (opcode <= OP_SHR);
`endif

    // The program RAM is only writable while the core is not executing.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pause holds FETCH/EXEC in place; IDLE and HALT only react to start.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (!pause) next_state = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (!pause) next_state = (opcode == OP_HALT) ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (start) next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        acc_next  = acc;
        cb_next   = CB;
        take_jump = 1'b0;
        case (opcode)
            OP_LDI: begin
                acc_next = operand;
                cb_next  = 1'b0;
            end
            OP_ADD: {cb_next, acc_next} = sum;
            OP_SUB: begin
                acc_next = acc - operand;
                cb_next  = (operand > acc);
            end
            OP_AND: acc_next = acc & operand;
            OP_OR:  acc_next = acc | operand;
            OP_XOR: acc_next = acc ^ operand;
            OP_SHL: begin
                cb_next  = acc[DATA_W-1];
                acc_next = {acc[DATA_W-2:0], 1'b0};
            end
            OP_SHR: begin
                cb_next  = acc[0];
                acc_next = {1'b0, acc[DATA_W-1:1]};
            end
            OP_JMP: take_jump = 1'b1;
            OP_JNC: take_jump = !CB;
            OP_JC:  take_jump = CB;
`ifdef ACC_PROCESSOR_ZFLAG_EN
            OP_JZ:  take_jump = Z;
`endif
            default: ;
        endcase
    end

    // PC wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            CB        <= 1'b0;
            Output    <= '0;
            out_valid <= 1'b0;
`ifdef ACC_PROCESSOR_ZFLAG_EN
            Z         <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                pc <= mode;
            end else if (!pause && state == FETCH) begin
                ir <= mem[pc];
            end else if (!pause && state == EXEC) begin
                acc <= acc_next;
                CB  <= cb_next;
`ifdef ACC_PROCESSOR_ZFLAG_EN
                if (acc_wr) Z <= (acc_next == '0);
`endif
                if (opcode == OP_OUT) begin
                    Output    <= acc;
                    out_valid <= 1'b1;
                end
                if (opcode != OP_HALT) begin
                    pc <= take_jump ? target : pc + 1'b1;
                end
            end
        end
    end

endmodule
